v1_pulse_gen: RTL and testbench
===============================

V1_PULSE_GEN -- requirements
Module: v1_pulse_gen

Interface
REQ-001 Parameter RISE_SHIFT, default 2, sets rise length to 2^RISE_SHIFT cycles.
REQ-002 Parameter DECAY_SHIFT, default 3, sets the decay constant: y <= y - (y >> DECAY_SHIFT).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  pulse request, accepted on a rising clk edge when ready=1.
REQ-006 amplitude  in  SIZE_IN_DATA  peak height, latched on acceptance.
REQ-007 period  in  SIZE_PERIOD  repeat interval in cycles, latched on acceptance; 0 selects single-shot.
REQ-008 stop  in  1  cancels periodic repetition.
REQ-009 ready  out  1  generator can accept start this cycle.
REQ-010 busy  out  1  high while in RISE or DECAY.
REQ-011 sample  out  SIZE_IN_DATA  registered synthetic detector signal, drives v1_filter input_data.
REQ-012 pulse_cnt  out  SIZE_PERIOD  accepted-pulse count, wraps at 2^SIZE_PERIOD.
REQ-013 overflow  out  1  sticky; set on any saturating addition.

Function
REQ-014 FSM states SHALL be IDLE, RISE, DECAY, HOLD; ready=1 in IDLE and HOLD.
REQ-015 Start accepted at edge N SHALL enter RISE and drive sample = amplitude>>RISE_SHIFT after edge N+1 (latency 1).
REQ-016 RISE SHALL add amplitude>>RISE_SHIFT per cycle for 2^RISE_SHIFT cycles; the final RISE cycle SHALL load exactly amplitude, after which the FSM enters DECAY.
REQ-017 DECAY SHALL apply y - (y>>DECAY_SHIFT) per cycle; when y>>DECAY_SHIFT==0, sample SHALL load 0 and the FSM SHALL leave DECAY.
REQ-018 On leaving DECAY: next state is HOLD if the latched period is nonzero, else IDLE.
REQ-019 The period counter SHALL start at acceptance; at expiry (period cycles later) it SHALL retrigger RISE with the latched amplitude and count a pulse.
REQ-020 A period expiry during RISE/DECAY SHALL be deferred; RISE starts on the cycle after DECAY ends.
REQ-021 Start in HOLD SHALL restart RISE with the newly latched amplitude/period.
REQ-022 stop SHALL clear the latched period in any state; the current pulse completes; HOLD goes to IDLE.
REQ-023 Simultaneous start and stop SHALL launch one pulse in single-shot mode.
REQ-024 amplitude=0 SHALL be counted, and sample SHALL stay 0 through RISE and the single DECAY cycle.
REQ-025 pulse_cnt SHALL increment once per accepted start or retrigger.

Reset
REQ-026 While reset=1: state IDLE, sample=0, pulse_cnt=0, overflow=0, busy=0, ready=1, latched period=0, independent of clk.
REQ-027 Reset asserted mid-pulse SHALL abort the pulse immediately; the first start after release behaves as from power-up.

Configuration
REQ-028 Macro V1_PULSE_PILEUP_EN defined: ready=1 also in DECAY; an accepted start adds amplitude to the current sample, saturating at 2^SIZE_IN_DATA-1 and setting overflow; the FSM stays in DECAY.
REQ-029 V1_PULSE_PILEUP_EN undefined: ready=0 in DECAY, start there SHALL be ignored, and overflow SHALL remain 0.

Structure
REQ-030 package_settings_V1 SHALL hold SIZE_IN_DATA, the new SIZE_PERIOD (16), and typedef pulse_state_t (IDLE, RISE, DECAY, HOLD).
REQ-031 The shift-subtract decay step with zero detection SHALL be a sub-module v1_decay_step.

Verification (SIZE_IN_DATA=12, RISE_SHIFT=2, DECAY_SHIFT=3)
REQ-032 start, amp=400, period=0 -> sample 100,200,300,400,350,307,269,... then 0; busy falls; pulse_cnt=1; state IDLE.
REQ-033 amp=80, period=100, stop at cycle 150 -> pulses start at cycles 0 and 100 only; pulse_cnt=2; state IDLE.
REQ-034 amp=800, period=5 -> each new RISE begins the cycle after sample returns to 0; no sample discontinuity.
REQ-035 PILEUP_EN, amp=4000, second start amp=400 at sample=3500 -> 3900; third start -> 4095, overflow=1. Without the macro -> ignored, pulse_cnt unchanged.
REQ-036 Reset pulse mid-DECAY -> sample=0, ready=1, pulse_cnt=0 before the next clk edge; a following start amp=400 reproduces REQ-032.

Source files
------------

// File: rtl/v1_pulse_gen_pkg.sv
// Shared sizes, FSM state type and saturating-add helper for the v1 pulse generator.
package package_settings_V1;

    localparam int SIZE_IN_DATA = 12;
    localparam int SIZE_PERIOD  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RISE  = 2'd1,
        DECAY = 2'd2,
        HOLD  = 2'd3
    } pulse_state_t;

    // Returns {overflow, value}; value clamps to all ones when the sum carries out.
    function automatic logic [SIZE_IN_DATA:0] sat_add(
        input logic [SIZE_IN_DATA-1:0] a,
        input logic [SIZE_IN_DATA-1:0] b
    );
        logic [SIZE_IN_DATA:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[SIZE_IN_DATA]) begin
            sat_add = {1'b1, {SIZE_IN_DATA{1'b1}}};
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/v1_pulse_gen_decay.sv
// One exponential-decay step y - (y >> DECAY_SHIFT); flags the point where the step vanishes.
module v1_decay_step #(
    parameter int WIDTH       = 12,
    parameter int DECAY_SHIFT = 3
) (
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_next,
    output logic             zero
);

    logic [WIDTH-1:0] delta_s;

    // Shift-subtract step; once the decrement is zero the tail is forced to 0.
    always_comb begin
        delta_s = y >> DECAY_SHIFT;
        zero    = (delta_s == {WIDTH{1'b0}});
        if (zero) begin
            y_next = {WIDTH{1'b0}};
        end else begin
            y_next = y - delta_s;
        end
    end

endmodule

// File: rtl/v1_pulse_gen.sv
// Synthetic detector pulse generator: linear rise, exponential decay, optional periodic repeat.
// Optional pile-up of new pulses onto a decaying tail is enabled by defining V1_PULSE_PILEUP_EN.
module v1_pulse_gen
    import package_settings_V1::*;
#(
    parameter int RISE_SHIFT  = 2,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SIZE_IN_DATA-1:0] amplitude,
    input  logic [SIZE_PERIOD-1:0]  period,
    input  logic                    stop,
    output logic                    ready,
    output logic                    busy,
    output logic [SIZE_IN_DATA-1:0] sample,
    output logic [SIZE_PERIOD-1:0]  pulse_cnt,
    output logic                    overflow
);

    localparam int RCW = RISE_SHIFT + 1;
    localparam logic [RCW-1:0]          RISE_LAST = RCW'((1 << RISE_SHIFT) - 1);
    localparam logic [RCW-1:0]          RISE_ONE  = RCW'(1);
    localparam logic [SIZE_IN_DATA-1:0] ZERO_D    = {SIZE_IN_DATA{1'b0}};
    localparam logic [SIZE_PERIOD-1:0]  ZERO_P    = {SIZE_PERIOD{1'b0}};
    localparam logic [SIZE_PERIOD-1:0]  ONE_P     = SIZE_PERIOD'(1);
`ifdef V1_PULSE_PILEUP_EN
    localparam logic READY_IN_DECAY = 1'b1;
`else
    localparam logic READY_IN_DECAY = 1'b0;
`endif

    pulse_state_t            state_r;
    logic [SIZE_IN_DATA-1:0] sample_r;
    logic [SIZE_IN_DATA-1:0] amp_r;
    logic [SIZE_PERIOD-1:0]  period_r;
    logic [SIZE_PERIOD-1:0]  cnt_r;
    logic [SIZE_PERIOD-1:0]  pulse_cnt_r;
    logic [RCW-1:0]          rise_cnt_r;
    logic                    pending_r;
    logic                    ready_r;
    logic                    busy_r;
    logic                    overflow_r;

    logic [SIZE_IN_DATA-1:0] step_s;
    logic [SIZE_IN_DATA-1:0] decay_next_s;
    logic                    decay_zero_s;
    logic                    accept_s;
    logic                    expire_s;
`ifdef V1_PULSE_PILEUP_EN
    logic [SIZE_IN_DATA:0]   pile_sum_s;
`endif

    // Rise increment, start acceptance and period expiry decode.
    always_comb begin
        step_s   = amp_r >> RISE_SHIFT;
        accept_s = start & ready_r;
        expire_s = (period_r != ZERO_P) && (cnt_r == ONE_P);
`ifdef V1_PULSE_PILEUP_EN
        pile_sum_s = sat_add(sample_r, amplitude);
`endif
    end

    v1_decay_step #(
        .WIDTH       (SIZE_IN_DATA),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_decay (
        .y      (sample_r),
        .y_next (decay_next_s),
        .zero   (decay_zero_s)
    );

    // Pulse FSM with registered sample, handshake, counters and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            sample_r    <= ZERO_D;
            amp_r       <= ZERO_D;
            period_r    <= ZERO_P;
            cnt_r       <= ZERO_P;
            pulse_cnt_r <= ZERO_P;
            rise_cnt_r  <= {RCW{1'b0}};
            pending_r   <= 1'b0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (cnt_r != ZERO_P) begin
                cnt_r <= cnt_r - ONE_P;
            end else begin
                cnt_r <= cnt_r;
            end

            case (state_r)
                IDLE, HOLD: begin
                    if (accept_s) begin
                        state_r     <= RISE;
                        ready_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        amp_r       <= amplitude;
                        pulse_cnt_r <= pulse_cnt_r + ONE_P;
                        rise_cnt_r  <= {RCW{1'b0}};
                        pending_r   <= 1'b0;
                        // A simultaneous stop turns the request into a single shot.
                        if (stop) begin
                            period_r <= ZERO_P;
                            cnt_r    <= ZERO_P;
                        end else begin
                            period_r <= period;
                            cnt_r    <= period;
                        end
                    end else if (stop || (period_r == ZERO_P)) begin
                        state_r   <= IDLE;
                        ready_r   <= 1'b1;
                        busy_r    <= 1'b0;
                        period_r  <= ZERO_P;
                        cnt_r     <= ZERO_P;
                        pending_r <= 1'b0;
                    end else if (pending_r || expire_s) begin
                        state_r     <= RISE;
                        ready_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        cnt_r       <= period_r;
                        pulse_cnt_r <= pulse_cnt_r + ONE_P;
                        rise_cnt_r  <= {RCW{1'b0}};
                        pending_r   <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end

                RISE: begin
                    if (stop) begin
                        period_r  <= ZERO_P;
                        cnt_r     <= ZERO_P;
                        pending_r <= 1'b0;
                    end else if (expire_s) begin
                        pending_r <= 1'b1;
                        cnt_r     <= ZERO_P;
                    end else begin
                        pending_r <= pending_r;
                    end
                    if (rise_cnt_r == RISE_LAST) begin
                        sample_r <= amp_r;
                        state_r  <= DECAY;
                        ready_r  <= READY_IN_DECAY;
                    end else begin
                        sample_r   <= sample_r + step_s;
                        rise_cnt_r <= rise_cnt_r + RISE_ONE;
                    end
                end

                DECAY: begin
`ifdef V1_PULSE_PILEUP_EN
                    if (accept_s) begin
                        sample_r    <= pile_sum_s[SIZE_IN_DATA-1:0];
                        overflow_r  <= overflow_r | pile_sum_s[SIZE_IN_DATA];
                        amp_r       <= amplitude;
                        pulse_cnt_r <= pulse_cnt_r + ONE_P;
                        pending_r   <= 1'b0;
                        if (stop) begin
                            period_r <= ZERO_P;
                            cnt_r    <= ZERO_P;
                        end else begin
                            period_r <= period;
                            cnt_r    <= period;
                        end
                    end else
`endif
                    begin
                        if (stop) begin
                            period_r  <= ZERO_P;
                            cnt_r     <= ZERO_P;
                            pending_r <= 1'b0;
                        end else if (expire_s) begin
                            pending_r <= 1'b1;
                            cnt_r     <= ZERO_P;
                        end else begin
                            pending_r <= pending_r;
                        end
                        if (decay_zero_s) begin
                            sample_r <= ZERO_D;
                            ready_r  <= 1'b1;
                            busy_r   <= 1'b0;
                            if (stop || (period_r == ZERO_P)) begin
                                state_r <= IDLE;
                            end else begin
                                state_r <= HOLD;
                            end
                        end else begin
                            sample_r <= decay_next_s;
                        end
                    end
                end

                default: begin
                    state_r  <= IDLE;
                    sample_r <= ZERO_D;
                    ready_r  <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign busy      = busy_r;
    assign sample    = sample_r;
    assign pulse_cnt = pulse_cnt_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_v1_pulse_gen.sv
// Scoreboard bench for v1_pulse_gen: expected sample streams are queued at stimulus time and popped by a monitor.
module tb_v1_pulse_gen;
    import package_settings_V1::*;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [SIZE_IN_DATA-1:0] amplitude;
    logic [SIZE_PERIOD-1:0]  period;
    logic                    stop;
    logic                    ready;
    logic                    busy;
    logic [SIZE_IN_DATA-1:0] sample;
    logic [SIZE_PERIOD-1:0]  pulse_cnt;
    logic                    overflow;

    int checks = 0;
    int errors = 0;
    int sb[$];

    v1_pulse_gen #(.RISE_SHIFT(2), .DECAY_SHIFT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .amplitude (amplitude),
        .period    (period),
        .stop      (stop),
        .ready     (ready),
        .busy      (busy),
        .sample    (sample),
        .pulse_cnt (pulse_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decay tail from y down to the last value whose decrement is zero, then the 0 the pulse ends on.
    task automatic push_decay(int y);
        int v;
        v = y;
        while ((v >> 3) != 0) begin
            v = v - (v >> 3);
            sb.push_back(v);
        end
        sb.push_back(0);
    endtask

    task automatic push_pulse(int amp);
        sb.push_back(0);
        for (int k = 1; k < 4; k++) sb.push_back(k * (amp >> 2));
        sb.push_back(amp);
        push_decay(amp);
    endtask

    task automatic push_hand400();
        int hand[8];
        hand = '{0, 100, 200, 300, 400, 350, 307, 269};
        foreach (hand[i]) sb.push_back(hand[i]);
        push_decay(269);
    endtask

    task automatic fire(int amp, int per, logic stp);
        start     = 1'b1;
        amplitude = SIZE_IN_DATA'(amp);
        period    = SIZE_PERIOD'(per);
        stop      = stp;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(string name, int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s idle timeout actual=busy required=idle", name);
        end
        tick();
    endtask

    task automatic wait_sample(string name, int v, int budget);
        int n;
        n = 0;
        while (int'(sample) != v && n < budget) begin
            tick();
            n++;
        end
        if (int'(sample) != v) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=%0d required=%0d", name, sample, v);
        end
    endtask

    task automatic wait_cnt(string name, int v, int budget);
        int n;
        n = 0;
        while (int'(pulse_cnt) != v && n < budget) begin
            tick();
            n++;
        end
        if (int'(pulse_cnt) != v) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=%0d required=%0d", name, pulse_cnt, v);
        end
    endtask

    // Monitor: every busy cycle plus the cycle after busy falls presents one sample.
    initial begin : monitor
        bit prev;
        int e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (busy || prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow actual=%0d required=no_output", sample);
                    end else begin
                        e = sb.pop_front();
                        check("sample", int'(sample), e);
                    end
                end
                prev = busy;
            end
        end
    end

    initial begin : stimulus
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        amplitude = '0;
        period    = '0;
        #1;
        check("rst_sample", int'(sample), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_pulse_cnt", int'(pulse_cnt), 0);
        check("rst_overflow", int'(overflow), 0);
        tick();
        tick();
        reset = 1'b0;

        // Single shot amp=400
        push_hand400();
        fire(400, 0, 1'b0);
        check("t1_busy_entry", int'(busy), 1);
        check("t1_ready_entry", int'(ready), 0);
        wait_idle("t1", 200);
        repeat (20) tick();
        check("t1_pulse_cnt", int'(pulse_cnt), 1);
        check("t1_ready", int'(ready), 1);
        check("t1_busy", int'(busy), 0);
        check("t1_drain", sb.size(), 0);

        // Zero amplitude still counts and stays flat
        do_reset();
        push_pulse(0);
        fire(0, 0, 1'b0);
        wait_idle("t2", 50);
        check("t2_pulse_cnt", int'(pulse_cnt), 1);
        check("t2_drain", sb.size(), 0);

        // Periodic amp=80 period=100, stop at cycle 150
        do_reset();
        push_pulse(80);
        fire(80, 100, 1'b0);
        repeat (99) tick();
        check("t3_busy_99", int'(busy), 0);
        check("t3_ready_99", int'(ready), 1);
        check("t3_cnt_99", int'(pulse_cnt), 1);
        check("t3_drain1", sb.size(), 0);
        push_pulse(80);
        tick();
        check("t3_busy_100", int'(busy), 1);
        check("t3_cnt_100", int'(pulse_cnt), 2);
        repeat (49) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (120) tick();
        check("t3_cnt_end", int'(pulse_cnt), 2);
        check("t3_busy_end", int'(busy), 0);
        check("t3_ready_end", int'(ready), 1);
        check("t3_drain2", sb.size(), 0);

        // Deferred expiry: amp=800 period=5 runs back to back
        do_reset();
        push_pulse(800);
        push_pulse(800);
        push_pulse(800);
        fire(800, 5, 1'b0);
        wait_cnt("t4_cnt3", 3, 400);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("t4", 200);
        repeat (20) tick();
        check("t4_pulse_cnt", int'(pulse_cnt), 3);
        check("t4_drain", sb.size(), 0);

        // Start and stop together: one single-shot pulse
        do_reset();
        push_pulse(120);
        fire(120, 3, 1'b1);
        wait_idle("t5", 100);
        repeat (20) tick();
        check("t5_pulse_cnt", int'(pulse_cnt), 1);
        check("t5_busy", int'(busy), 0);
        check("t5_drain", sb.size(), 0);

        // Start in HOLD relatches amplitude and period
        do_reset();
        push_pulse(80);
        fire(80, 200, 1'b0);
        wait_idle("t6a", 100);
        check("t6_ready_hold", int'(ready), 1);
        push_pulse(40);
        fire(40, 0, 1'b0);
        check("t6_cnt_restart", int'(pulse_cnt), 2);
        wait_idle("t6b", 100);
        repeat (220) tick();
        check("t6_cnt_end", int'(pulse_cnt), 2);
        check("t6_drain", sb.size(), 0);

        // Start during DECAY: pile-up or ignored
        do_reset();
`ifdef V1_PULSE_PILEUP_EN
        begin
            int pile[8];
            pile = '{0, 1000, 2000, 3000, 4000, 3500, 3900, 4095};
            foreach (pile[i]) sb.push_back(pile[i]);
            push_decay(4095);
        end
`else
        push_pulse(4000);
`endif
        fire(4000, 0, 1'b0);
        wait_sample("t7_3500", 3500, 20);
        start     = 1'b1;
        amplitude = SIZE_IN_DATA'(400);
        tick();
        tick();
        start = 1'b0;
        wait_idle("t7", 300);
`ifdef V1_PULSE_PILEUP_EN
        check("t7_pulse_cnt", int'(pulse_cnt), 3);
        check("t7_overflow", int'(overflow), 1);
`else
        check("t7_pulse_cnt", int'(pulse_cnt), 1);
        check("t7_overflow", int'(overflow), 0);
`endif
        check("t7_drain", sb.size(), 0);

        // Asynchronous reset mid-DECAY, then power-up-like restart
        do_reset();
        push_pulse(400);
        fire(400, 0, 1'b0);
        wait_sample("t8_269", 269, 20);
        reset = 1'b1;
        #1;
        check("t8_sample", int'(sample), 0);
        check("t8_ready", int'(ready), 1);
        check("t8_busy", int'(busy), 0);
        check("t8_pulse_cnt", int'(pulse_cnt), 0);
        sb.delete();
        tick();
        reset = 1'b0;
        push_hand400();
        fire(400, 0, 1'b0);
        wait_idle("t8", 200);
        check("t8_cnt_after", int'(pulse_cnt), 1);
        check("t8_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
